step_scheduler: RTL
===================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 500000, giving system clocks per step tick (50 MHz to 100 Hz).
REQ-002 SHALL have parameter LEN_W, default 10, giving the width of the step-length and gate-length fields.
REQ-003 clk  input  1  system clock (50 MHz); all logic SHALL be on the rising edge of clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; high requests sequencing, low requests stop.
REQ-006 step_len  input  LEN_W  requested step duration in ticks.
REQ-007 gate_len  input  LEN_W  requested note-on duration in ticks.
REQ-008 len_load  input  1  when high, step_len and gate_len are captured into shadow registers.
REQ-009 step  output  4  index of the current step, 0..15.
REQ-010 load_strobe  output  16  one-hot, single-cycle strobe that loads the frequency memory register of the starting step.
REQ-011 gate  output  16  one-hot note-on to the ADSR of the current step.
REQ-012 tick  output  1  single-cycle prescaler pulse, once every CLK_DIV clocks.
REQ-013 end_count  output  1  single-cycle pulse when the step index wraps from 15 to 0.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap, asserting tick for the cycle in which the count equals CLK_DIV-1.
REQ-016 Prescaler SHALL be forced to 0 on the IDLE-to-STEP_ON transition, so that step timing is phase-locked to the start of a run.
REQ-017 len_load high SHALL capture the shadow registers on the same edge, in any state; a value of 0 for step_len SHALL be stored as 1.
REQ-018 At every step start, the shadow registers SHALL be copied into active registers; changes therefore apply from the next step start, never mid-step.
REQ-019 FSM states SHALL be IDLE, STEP_ON (gate high) and STEP_OFF (gate low, waiting for the step to end).
REQ-020 IDLE with run=1: on the next edge, step=0, load_strobe=16'h0001 for one cycle, prescaler=0, tick counter=0, and the FSM SHALL enter STEP_ON, or STEP_OFF if active gate_len=0.
REQ-021 In STEP_ON and STEP_OFF, the tick counter SHALL increment on each tick.
REQ-022 When the counter reaches active gate_len, gate SHALL go low on the next cycle and the FSM SHALL enter STEP_OFF.
REQ-023 If gate_len >= step_len, gate SHALL stay high for the whole step, with no STEP_OFF phase.
REQ-024 When the counter reaches active step_len, the next cycle SHALL be a step start.
  - step increments modulo 16.
  - load_strobe and gate assert the new one-hot bit.
  - The counter clears.
REQ-025 With constant lengths, consecutive step starts SHALL be exactly step_len*CLK_DIV cycles apart, and gate SHALL be high for exactly min(gate_len, step_len)*CLK_DIV cycles from the step start.
REQ-026 end_count SHALL assert in the same cycle as load_strobe[0] on a 15-to-0 wrap, and never on the initial start from IDLE.
REQ-027 run=0 during a step SHALL let the current step finish.
  - At its end, the FSM enters IDLE; step, gate and load_strobe go to 0.
  - end_count asserts only if the finished step was 15.
REQ-028 run re-asserted before the current step ends SHALL cancel the pending stop with no glitch on any output.
REQ-029 gate SHALL be all-zero in IDLE and STEP_OFF, and SHALL have at most one bit set at any time.
REQ-030 load_strobe SHALL have at most one bit set and SHALL never be high in two consecutive cycles.

Reset
REQ-031 On reset=1, the block SHALL return to the following state on the next edge, overriding run and len_load:
  - FSM = IDLE.
  - step = 0, load_strobe = 0, gate = 0, tick = 0, end_count = 0, busy = 0.
  - Prescaler = 0 and tick counter = 0.
  - Shadow and active step_len = 1; shadow and active gate_len = 1.
REQ-032 Reset mid-step SHALL drop gate within one cycle and SHALL produce no load_strobe or end_count pulse.

Verification (CLK_DIV=4)
REQ-033 Reset release, then len_load with step_len=2 and gate_len=1, then run=1 -> load_strobe=0001 one cycle later; gate[0] high for 4 cycles; load_strobe=0002 at start+8.
REQ-034 Run continuously with step_len=1 -> step visits 0..15; end_count pulses with load_strobe[0] at start+64 and every 64 cycles after.
REQ-035 gate_len=0 -> gate stays 0 for all steps while load_strobe still pulses every step.
REQ-036 len_load with step_len=3 issued mid-step 2 -> step 2 keeps its old length; step 3 lasts 12 cycles.
REQ-037 run=0 during step 5 -> step 5 completes; then busy=0, step=0, no end_count.
REQ-038 reset asserted during STEP_ON of step 7 -> all outputs 0 on the next edge; a later run restarts at step 0.

Source files
------------

// File: rtl/step_scheduler.sv
// Sixteen-step sequencer: a prescaler turns clk into step ticks, and an FSM
// walks step 0..15, issuing a one-hot load_strobe and gate for each step.
// Ports: clk, reset (sync, active high), run, step_len/gate_len/len_load
// (shadowed length update); step, load_strobe, gate, tick, end_count, busy.
module step_scheduler #(
    parameter int CLK_DIV = 500000,
    parameter int LEN_W   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [LEN_W-1:0] step_len,
    input  logic [LEN_W-1:0] gate_len,
    input  logic             len_load,
    output logic [3:0]       step,
    output logic [15:0]      load_strobe,
    output logic [15:0]      gate,
    output logic             tick,
    output logic             end_count,
    output logic             busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STEP_ON  = 2'd1,
        STEP_OFF = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   presc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] sh_step, sh_gate;
    logic [LEN_W-1:0] act_step, act_gate;

    logic            start_run;
    logic            step_end;
    logic            gate_hit;
    logic [LEN_W:0]  cnt_inc;
    logic [3:0]      step_inc;

    assign tick      = (presc == PMAX);
    assign cnt_inc   = {1'b0, cnt} + 1'b1;
    assign step_inc  = step + 4'd1;
    assign start_run = (state == IDLE) && run;
    // The tick that brings the counter to a length acts on that same edge,
    // so each phase lasts exactly length*CLK_DIV cycles.
    assign step_end  = (state != IDLE) && tick &&
                       (cnt_inc == {1'b0, act_step});
    assign gate_hit  = (state == STEP_ON) && tick &&
                       (cnt_inc == {1'b0, act_gate});

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a new step decides ON/OFF from the shadow gate
    // length because that is what becomes active on the same edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (run)
                    state_nx = (sh_gate == '0) ? STEP_OFF : STEP_ON;
            end
            STEP_ON, STEP_OFF: begin
                if (step_end) begin
                    if (run)
                        state_nx = (sh_gate == '0) ? STEP_OFF : STEP_ON;
                    else
                        state_nx = IDLE;
                end else if (gate_hit) begin
                    state_nx = STEP_OFF;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
        gate = '0;
        if (state == STEP_ON)
            gate = 16'(1) << step;
    end

    // Datapath: prescaler, tick counter, step index, strobes, lengths
    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            cnt         <= '0;
            step        <= '0;
            load_strobe <= '0;
            end_count   <= 1'b0;
            sh_step     <= LEN_W'(1);
            sh_gate     <= LEN_W'(1);
            act_step    <= LEN_W'(1);
            act_gate    <= LEN_W'(1);
        end else begin
            if (start_run || tick) presc <= '0;
            else                   presc <= presc + 1'b1;

            if (len_load) begin
                sh_step <= (step_len == '0) ? LEN_W'(1) : step_len;
                sh_gate <= gate_len;
            end

            load_strobe <= '0;
            end_count   <= 1'b0;

            if (start_run) begin
                cnt         <= '0;
                step        <= '0;
                load_strobe <= 16'h0001;
                act_step    <= sh_step;
                act_gate    <= sh_gate;
            end else if (step_end) begin
                cnt       <= '0;
                end_count <= (step == 4'd15);
                if (run) begin
                    step        <= step_inc;
                    load_strobe <= 16'(1) << step_inc;
                    act_step    <= sh_step;
                    act_gate    <= sh_gate;
                end else begin
                    step <= '0;
                end
            end else if (busy && tick) begin
                cnt <= cnt_inc[LEN_W-1:0];
            end
        end
    end

endmodule
